// File: rtl/mitm_frame_controller.sv
// mitm_frame_controller
// Per-frame sequencer for the EEPROM man-in-the-middle datapath. It follows
// each SPI frame (3-bit opcode, 9-bit address, 8-bit data) from synchronized
// bus events. It owns the active MITM mode and applies mode changes only
// between frames. It also tells the output muxes when to replace a sniffed bit
// with a bit of the programmed replacement byte.
//
// Handshake: there is no valid/ready pair. Every input event is a single-cycle
// qualifier: sclk_rise marks the one cycle in which mosi_bit is valid, and
// mode_next marks one button press. ss_active is a level. All outputs are
// registered and change only on sys_clk.
module mitm_frame_controller #(
    parameter int          NUM_MITM_MODES  = 3,
    parameter int          DATA_FRAME_SIZE = 20,
    parameter logic [2:0]  READ_OPCODE     = 3'b110,
    parameter logic [2:0]  WRITE_OPCODE    = 3'b101,
    parameter logic [7:0]  SUB_DATA        = 8'hff
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,
    input  logic                      mode_next,
    input  logic                      ss_active,
    input  logic                      sclk_rise,
    input  logic                      mosi_bit,
    output logic [NUM_MITM_MODES-1:0] mode_sel,
    output logic                      comm_active,
    output logic                      miso_sub_en,
    output logic                      miso_sub_bit,
    output logic                      mosi_sub_en,
    output logic                      mosi_sub_bit,
    output logic [2:0]                frame_opcode,
    output logic [8:0]                frame_addr,
    output logic                      frame_done,
    output logic                      frame_abort,
    output logic [2:0]                dbg_state_o
);

    localparam int CNT_W = $clog2(DATA_FRAME_SIZE + 2);

    // Bit counts at which the header fields are complete and the frame is full.
    localparam logic [CNT_W-1:0] CNT_OPC  = CNT_W'(3);
    localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(12);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_FRAME_SIZE);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_FRAME_SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_FRAME_SIZE - 1);

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_HEADER    = 3'd2,
        ST_DATA      = 3'd3,
        ST_TAIL      = 3'd4
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]                shift_q, shift_d;
    logic [2:0]                opcode_q, opcode_d;
    logic [8:0]                addr_q, addr_d;
    logic [NUM_MITM_MODES-1:0] mode_sel_q, mode_sel_d;
    logic                      pending_q, pending_d;
    logic                      comm_q, comm_d;
    logic                      miso_en_q, miso_en_d;
    logic                      miso_bit_q, miso_bit_d;
    logic                      mosi_en_q, mosi_en_d;
    logic                      mosi_bit_q, mosi_bit_d;
    logic                      done_q, done_d;
    logic                      abort_q, abort_d;

    // Helper terms shared by the header and data paths.
    logic [CNT_W-1:0]          cnt_inc;
    logic [8:0]                shift_in;
    logic [2:0]                sub_idx;
    logic                      sub_bit;
    logic                      read_match;
    logic                      write_match;
    logic [NUM_MITM_MODES-1:0] mode_rot;

    // Derive the next bit count, the shifted header, the replacement bit and the
    // mode-match terms.
    always_comb begin
        cnt_inc     = bit_cnt_q + CNT_W'(1);
        shift_in    = {shift_q, mosi_bit};
        // Replacement byte goes out MSB first: bit 12 carries SUB_DATA[7].
        sub_idx     = 3'(CNT_LAST - cnt_inc);
        sub_bit     = SUB_DATA[sub_idx];
        read_match  = mode_sel_q[1] && (opcode_q == READ_OPCODE);
        write_match = mode_sel_q[2] && (opcode_q == WRITE_OPCODE);
        mode_rot    = {mode_sel_q[NUM_MITM_MODES-2:0], mode_sel_q[NUM_MITM_MODES-1]};
    end

    // Frame FSM next state and registered outputs. The mode is handled here too.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        opcode_d   = opcode_q;
        addr_d     = addr_q;
        mode_sel_d = mode_sel_q;
        pending_d  = pending_q;
        comm_d     = comm_q;
        miso_en_d  = miso_en_q;
        miso_bit_d = miso_bit_q;
        mosi_en_d  = mosi_en_q;
        mosi_bit_d = mosi_bit_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;

        case (state_q)
            ST_WAIT_IDLE: begin
                // After a reset mid-frame, the rest of that frame is ignored.
                comm_d     = 1'b0;
                miso_en_d  = 1'b0;
                mosi_en_d  = 1'b0;
                miso_bit_d = 1'b0;
                mosi_bit_d = 1'b0;
                if (!ss_active) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (ss_active) begin
                    state_d   = ST_HEADER;
                    comm_d    = 1'b1;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end

            ST_HEADER, ST_DATA, ST_TAIL: begin
                if (!ss_active) begin
                    // The end of the frame takes priority over a coincident SCLK edge.
                    state_d    = ST_IDLE;
                    comm_d     = 1'b0;
                    miso_en_d  = 1'b0;
                    mosi_en_d  = 1'b0;
                    miso_bit_d = 1'b0;
                    mosi_bit_d = 1'b0;
                    done_d     = (bit_cnt_q == CNT_FULL);
                    abort_d    = (bit_cnt_q != CNT_FULL);
                end else if (sclk_rise) begin
                    if (state_q == ST_HEADER) begin
                        bit_cnt_d = cnt_inc;
                        shift_d   = shift_in[7:0];
                        if (cnt_inc == CNT_OPC) begin
                            opcode_d = shift_in[2:0];
                        end
                        if (cnt_inc == CNT_HDR) begin
                            // The opcode is already latched, so the first data
                            // bit can be qualified straight away.
                            addr_d     = shift_in;
                            state_d    = ST_DATA;
                            miso_en_d  = read_match;
                            mosi_en_d  = write_match;
                            miso_bit_d = read_match & sub_bit;
                            mosi_bit_d = write_match & sub_bit;
                        end
                    end else if (state_q == ST_DATA) begin
                        bit_cnt_d = cnt_inc;
                        if (cnt_inc == CNT_FULL) begin
                            state_d    = ST_TAIL;
                            miso_en_d  = 1'b0;
                            mosi_en_d  = 1'b0;
                            miso_bit_d = 1'b0;
                            mosi_bit_d = 1'b0;
                        end else begin
                            miso_bit_d = miso_en_q & sub_bit;
                            mosi_bit_d = mosi_en_q & sub_bit;
                        end
                    end else begin
                        // Overlong frames are counted up to one past full, then held.
                        if (bit_cnt_q != CNT_SAT) begin
                            bit_cnt_d = cnt_inc;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_WAIT_IDLE;
            end
        endcase

        // A mode change is applied only while idle. A change that is already
        // pending goes first, even if a frame starts in the same cycle. Any
        // other press becomes pending until the next idle period.
        if (state_q == ST_IDLE) begin
            if (pending_q) begin
                mode_sel_d = mode_rot;
                pending_d  = 1'b0;
            end else if (mode_next) begin
                if (ss_active) begin
                    pending_d = 1'b1;
                end else begin
                    mode_sel_d = mode_rot;
                end
            end
        end else if (mode_next) begin
            pending_d = 1'b1;
        end
    end

    // State and output registers. Reset is asynchronous and active low.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_WAIT_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            opcode_q   <= '0;
            addr_q     <= '0;
            mode_sel_q <= NUM_MITM_MODES'(1);
            pending_q  <= 1'b0;
            comm_q     <= 1'b0;
            miso_en_q  <= 1'b0;
            miso_bit_q <= 1'b0;
            mosi_en_q  <= 1'b0;
            mosi_bit_q <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            opcode_q   <= opcode_d;
            addr_q     <= addr_d;
            mode_sel_q <= mode_sel_d;
            pending_q  <= pending_d;
            comm_q     <= comm_d;
            miso_en_q  <= miso_en_d;
            miso_bit_q <= miso_bit_d;
            mosi_en_q  <= mosi_en_d;
            mosi_bit_q <= mosi_bit_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    assign mode_sel     = mode_sel_q;
    assign comm_active  = comm_q;
    assign miso_sub_en  = miso_en_q;
    assign miso_sub_bit = miso_bit_q;
    assign mosi_sub_en  = mosi_en_q;
    assign mosi_sub_bit = mosi_bit_q;
    assign frame_opcode = opcode_q;
    assign frame_addr   = addr_q;
    assign frame_done   = done_q;
    assign frame_abort  = abort_q;
    assign dbg_state_o  = state_q;

endmodule

// File: doc/mitm_frame_controller.md
# mitm_frame_controller

Per-frame sequencer for the EEPROM man-in-the-middle datapath. It tracks each 20-bit SPI frame (3-bit opcode, 9-bit address, 8-bit data) from synchronized bus events. It owns the active MITM mode and applies button-driven mode changes only between frames. For each bit it tells the output mux whether to forward the sniffed MISO/MOSI bit or substitute a bit of the programmed replacement byte.

## Interface
Parameters:
- NUM_MITM_MODES, 3, number of modes; mode_sel is one-hot of this width
- DATA_FRAME_SIZE, 20, bits per frame
- READ_OPCODE, 3'b110, opcode whose MISO data byte is substituted in mode 1
- WRITE_OPCODE, 3'b101, opcode whose MOSI data byte is substituted in mode 2
- SUB_DATA, 8'hff, replacement byte, sent MSB first

Ports:
- sys_clk  in  1  system clock, ≥20× SCLK rate; the block's only clock
- rst_n  in  1  reset, asynchronous, active-low
- mode_next  in  1  one-cycle pulse from the debounced mode button
- ss_active  in  1  synchronized slave-select, 1 = frame in progress
- sclk_rise  in  1  one-cycle pulse per synchronized SCLK rising edge
- mosi_bit  in  1  synchronized MOSI, valid in the sclk_rise cycle
- mode_sel  out  NUM_MITM_MODES  one-hot active mode (drives mode_leds)
- comm_active  out  1  high while a frame is tracked
- miso_sub_en / miso_sub_bit  out  1/1  MISO mux select / substitute bit
- mosi_sub_en / mosi_sub_bit  out  1/1  MOSI mux select / substitute bit
- frame_opcode  out  3  opcode of the last header
- frame_addr  out  9  address of the last header
- frame_done  out  1  one-cycle pulse: frame ended with exactly DATA_FRAME_SIZE bits
- frame_abort  out  1  one-cycle pulse: frame ended with any other bit count

## Operation
- Modes: 0 FORWARD (never substitute), 1 SUB_READ (READ_OPCODE frames: MISO data bits ← SUB_DATA), 2 SUB_WRITE (WRITE_OPCODE frames: MOSI data bits ← SUB_DATA).
- mode_next sets mode_pending. In IDLE, a pending change advances the mode by one, wrapping from 2 to 0, and clears pending. Extra pulses while a change is pending are ignored.
- FSM:
  - WAIT_IDLE (state after reset): go to IDLE when ss_active = 0.
  - IDLE: go to HEADER when ss_active = 1. On entry to HEADER, clear bit_cnt and the shift register.
  - HEADER: each sclk_rise shifts mosi_bit in and increments bit_cnt. At bit_cnt = 3, latch frame_opcode. At bit_cnt = 12, latch frame_addr and enter DATA.
  - DATA: bits 12..19. At bit_cnt = 20, enter TAIL.
  - TAIL: further sclk_rise pulses are counted (bit_cnt saturates at DATA_FRAME_SIZE+1) and forwarded, never substituted.
  - Any state except WAIT_IDLE/IDLE: when ss_active = 0, return to IDLE and pulse frame_done if bit_cnt = 20, otherwise pulse frame_abort.
- Substitution: sub_en is high in DATA when the mode matches and the latched opcode matches. The substitute bit is SUB_DATA[19 − bit_cnt]. Outside DATA, both sub_en are 0.
- bit_cnt width is $clog2(DATA_FRAME_SIZE+2). Arithmetic is unsigned.
- comm_active = 1 in HEADER, DATA and TAIL.

## Timing
- Reset values: mode_sel = 001, comm_active = 0, all sub_en/sub_bit = 0, frame_opcode = 0, frame_addr = 0, frame_done = 0, frame_abort = 0, mode_pending = 0. Reset state is WAIT_IDLE.
- All outputs are registered.
- sub_en and sub_bit update 1 cycle after the sclk_rise that completes bit 11 (and each later bit). This places them before the next SCLK rising edge, since SCLK half-period is ≥10 cycles.
- sub_en drops 1 cycle after the sclk_rise of bit 19.
- Mode change: mode_sel updates 1 cycle after mode_next when in IDLE. If the pulse arrives in a frame, mode_sel updates 1 cycle after the return to IDLE.
- comm_active rises 1 cycle after ss_active rises. It falls together with the frame_done/frame_abort pulse, 1 cycle after ss_active falls.
- Simultaneous events:
  - sclk_rise with ss_active falling: ss wins; the bit is discarded.
  - mode_next in the same cycle as IDLE→HEADER: pending; applied after that frame.
  - ss_active rising in the same cycle a pending change is applied: the change is applied and the new frame is entered next cycle with the new mode.
- Asynchronous reset mid-frame forces all reset values immediately. The block stays in WAIT_IDLE until ss_active = 0, so the partial frame is never substituted.

## Test plan
- Read frame {110, 9'h09a, 8'h00} in mode 0 → miso_sub_en/mosi_sub_en stay 0, frame_opcode = 110, frame_addr = 0x09a, one frame_done, no frame_abort.
- mode_next in IDLE → mode_sel 001→010 one cycle later. Then read frame {110, 9'h120} with MISO 0xb5 → miso_sub_en high for exactly bits 12..19, miso_sub_bit serializes 0xff, mosi_sub_en stays 0.
- mode_next during bit 5 of a frame in mode 1 → mode_sel stays 010 until ss_active falls, then becomes 100. The current frame still substitutes MISO.
- Mode 2, write frame {101, 9'h037, 8'h6d} → mosi_sub_en high for bits 12..19, mosi_sub_bit = 0xff. A following read frame gets no substitution.
- ss_active drops after 7 bits → frame_abort pulse, no frame_done, no sub_en. Also test a 22-bit frame → frame_abort, with bits 20..21 not substituted.
- Assert rst_n low at bit 14 of a mode-1 read, release with ss_active still high → mode_sel = 001 and sub_en = 0 for the rest of the frame. The next full frame is tracked normally.
